// File: rtl/comp2_to_signmag_bcd_pkg.sv
// Shared definitions for the two's-complement to sign/magnitude/BCD converter:
// FSM state encoding, BCD adjust constants and an elaboration-time helper.
package comp2_to_signmag_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Used only at elaboration to confirm the BCD field can hold the largest magnitude.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
    import comp2_to_signmag_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ) : digit;

endmodule

// File: rtl/comp2_to_signmag_bcd.sv
// Converts a two's-complement operand into sign, unsigned magnitude and packed BCD.
// Magnitude is recovered on acceptance, then BCD is built one bit per clock.
module comp2_to_signmag_bcd
    import comp2_to_signmag_bcd_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int N_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      A,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sign,
    output logic [WIDTH-1:0]      mag,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // The most negative input has magnitude 2^(WIDTH-1), which must fit in the digits.
    if (pow10(N_DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_bad_params
        $error("comp2_to_signmag_bcd: N_DIGITS too small for WIDTH");
    end

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [WIDTH-1:0]   a_mag;

    // Negating -2^(WIDTH-1) wraps back to itself, which read as unsigned is the right magnitude.
    assign a_mag = A[WIDTH-1] ? ((~A) + WIDTH'(1)) : A;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit    (bcd[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Handshake FSM with registered ready/valid; bcd doubles as the working BCD accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign      <= A[WIDTH-1];
                        mag       <= a_mag;
                        shift_reg <= a_mag;
                        bcd       <= '0;
                        bit_cnt   <= CNT_W'(WIDTH);
                        in_ready  <= 1'b0;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    bit_cnt          <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
